// File: rtl/conv_window_addr_gen_if.sv
// Address stream between the window address generator and its consumer.
// The producer drives the address, the valid flag and the window/frame markers.
// The consumer drives ready.
interface conv_window_addr_gen_if #(
    parameter int AddrBits = 16
) ();
    logic [AddrBits-1:0] addr;
    logic                valid;
    logic                ready;
    logic                win_last;
    logic                frame_last;

    modport master (
        output addr,
        output valid,
        output win_last,
        output frame_last,
        input  ready
    );

    modport slave (
        input  addr,
        input  valid,
        input  win_last,
        input  frame_last,
        output ready
    );
endinterface

// File: rtl/conv_window_addr_gen.sv
// Nested-loop address engine for KxK convolution windows in raster order.
// Loop order from innermost to outermost: kx, ky, ox, oy.
// Addresses are stepped incrementally using running row, window and tap bases.
// The output window count is never divided out. A window position is the last
// one on its axis when the next stride step would no longer fit (pos + S > W - K).
module conv_window_addr_gen #(
    parameter int AddrBits = 16,
    parameter int DimBits  = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [DimBits-1:0]  img_width_i,
    input  logic [DimBits-1:0]  img_height_i,
    input  logic [DimBits-1:0]  kernel_size_i,
    input  logic [DimBits-1:0]  stride_i,
    input  logic [AddrBits-1:0] base_addr_i,
    conv_window_addr_gen_if.master stream,
    output logic                busy_o,
    output logic                done_o,
    output logic                cfg_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DimBits-1:0]  DimOne  = DimBits'(1);
    localparam logic [AddrBits-1:0] AddrOne = AddrBits'(1);

    // Returns 1 when a window origin at pos cannot advance by step within limit (= dim - K).
    function automatic logic pos_is_last(input logic [DimBits-1:0] pos,
                                         input logic [DimBits-1:0] step,
                                         input logic [DimBits-1:0] limit);
        return ({1'b0, pos} + {1'b0, step}) > {1'b0, limit};
    endfunction

    state_t              state_q;

    // Configuration latched on the accepted start cycle.
    logic [DimBits-1:0]  km1_q;       // K-1
    logic [DimBits-1:0]  s_q;         // stride
    logic [DimBits-1:0]  wmk_q;       // W-K
    logic [DimBits-1:0]  hmk_q;       // H-K
    logic [AddrBits-1:0] w_step_q;    // one image row
    logic [AddrBits-1:0] s_step_q;    // one horizontal stride
    logic [AddrBits-1:0] row_step_q;  // S image rows

    // Loop counters. col_q and row_q hold the window origin in pixels (ox*S, oy*S).
    logic [DimBits-1:0]  kx_q, ky_q, col_q, row_q;
    logic [AddrBits-1:0] line_q;      // base + oy*S*W
    logic [AddrBits-1:0] win_q;       // line + ox*S
    logic [AddrBits-1:0] tap_q;       // win + ky*W

    // Registered stream outputs.
    logic [AddrBits-1:0] addr_q;
    logic                valid_q, win_last_q, frame_last_q;

    // Next-beat values.
    logic [DimBits-1:0]  nxt_kx, nxt_ky, nxt_col, nxt_row;
    logic [AddrBits-1:0] nxt_line, nxt_win, nxt_tap, nxt_addr;
    logic                nxt_final, nxt_win_last, nxt_frame_last;

    // Start-cycle decode from the raw inputs.
    logic                cfg_ok;
    logic [DimBits-1:0]  in_wmk, in_hmk;
    logic [2*DimBits-1:0] in_sw;
    logic                first_win_last, first_frame_last;

    assign cfg_ok = (kernel_size_i != '0) && (stride_i != '0) &&
                    (kernel_size_i <= img_width_i) && (kernel_size_i <= img_height_i);
    assign in_wmk = img_width_i - kernel_size_i;
    assign in_hmk = img_height_i - kernel_size_i;
    assign in_sw  = (2*DimBits)'(stride_i) * (2*DimBits)'(img_width_i);
    assign first_win_last   = (kernel_size_i == DimOne);
    assign first_frame_last = first_win_last &&
                              pos_is_last('0, stride_i, in_wmk) &&
                              pos_is_last('0, stride_i, in_hmk);

    // Step the nested loops by one tap and derive the flags of the following beat.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and no latch is inferred.
        nxt_kx    = kx_q;
        nxt_ky    = ky_q;
        nxt_col   = col_q;
        nxt_row   = row_q;
        nxt_line  = line_q;
        nxt_win   = win_q;
        nxt_tap   = tap_q;
        nxt_addr  = addr_q;
        nxt_final = 1'b0;
        if (kx_q != km1_q) begin
            nxt_kx   = kx_q + DimOne;
            nxt_addr = addr_q + AddrOne;
        end else if (ky_q != km1_q) begin
            nxt_kx   = '0;
            nxt_ky   = ky_q + DimOne;
            nxt_tap  = tap_q + w_step_q;
            nxt_addr = nxt_tap;
        end else if (!pos_is_last(col_q, s_q, wmk_q)) begin
            nxt_kx   = '0;
            nxt_ky   = '0;
            nxt_col  = col_q + s_q;
            nxt_win  = win_q + s_step_q;
            nxt_tap  = nxt_win;
            nxt_addr = nxt_win;
        end else if (!pos_is_last(row_q, s_q, hmk_q)) begin
            nxt_kx   = '0;
            nxt_ky   = '0;
            nxt_col  = '0;
            nxt_row  = row_q + s_q;
            nxt_line = line_q + row_step_q;
            nxt_win  = nxt_line;
            nxt_tap  = nxt_line;
            nxt_addr = nxt_line;
        end else begin
            nxt_final = 1'b1;
        end
        nxt_win_last   = (nxt_kx == km1_q) && (nxt_ky == km1_q);
        nxt_frame_last = nxt_win_last &&
                         pos_is_last(nxt_col, s_q, wmk_q) &&
                         pos_is_last(nxt_row, s_q, hmk_q);
    end

    // Control FSM with counters and registered outputs. The reset is synchronous.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q      <= IDLE;
            km1_q        <= '0;
            s_q          <= '0;
            wmk_q        <= '0;
            hmk_q        <= '0;
            w_step_q     <= '0;
            s_step_q     <= '0;
            row_step_q   <= '0;
            kx_q         <= '0;
            ky_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
            line_q       <= '0;
            win_q        <= '0;
            tap_q        <= '0;
            addr_q       <= '0;
            valid_q      <= 1'b0;
            win_last_q   <= 1'b0;
            frame_last_q <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            cfg_err_o    <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            cfg_err_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (cfg_ok) begin
                            state_q      <= RUN;
                            km1_q        <= kernel_size_i - DimOne;
                            s_q          <= stride_i;
                            wmk_q        <= in_wmk;
                            hmk_q        <= in_hmk;
                            w_step_q     <= AddrBits'(img_width_i);
                            s_step_q     <= AddrBits'(stride_i);
                            row_step_q   <= AddrBits'(in_sw);
                            kx_q         <= '0;
                            ky_q         <= '0;
                            col_q        <= '0;
                            row_q        <= '0;
                            line_q       <= base_addr_i;
                            win_q        <= base_addr_i;
                            tap_q        <= base_addr_i;
                            addr_q       <= base_addr_i;
                            valid_q      <= 1'b1;
                            win_last_q   <= first_win_last;
                            frame_last_q <= first_frame_last;
                            busy_o       <= 1'b1;
                        end else begin
                            cfg_err_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (valid_q && stream.ready) begin
                        if (nxt_final) begin
                            state_q      <= DONE;
                            valid_q      <= 1'b0;
                            win_last_q   <= 1'b0;
                            frame_last_q <= 1'b0;
                            busy_o       <= 1'b0;
                            done_o       <= 1'b1;
                        end else begin
                            kx_q         <= nxt_kx;
                            ky_q         <= nxt_ky;
                            col_q        <= nxt_col;
                            row_q        <= nxt_row;
                            line_q       <= nxt_line;
                            win_q        <= nxt_win;
                            tap_q        <= nxt_tap;
                            addr_q       <= nxt_addr;
                            win_last_q   <= nxt_win_last;
                            frame_last_q <= nxt_frame_last;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stream.addr       = addr_q;
    assign stream.valid      = valid_q;
    assign stream.win_last   = win_last_q;
    assign stream.frame_last = frame_last_q;

endmodule
